// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with an internal
// register file and ALU. Instruction and data memories sit behind req/ack ports.
module mc_cpu_core #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 5,
  parameter int DADDR_W = 7,
  parameter int NREG    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               halted,
  output logic               illegal,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        retired
);
  localparam int RI_W = $clog2(NREG);
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h1C;
  localparam logic [5:0] OP_SW   = 6'h14;
  localparam logic [5:0] OP_BEQ  = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [PC_W-1:0] PC_ONE = 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [15:0]       retired_q, retired_d;
  logic              halted_q, halted_d, illegal_q, illegal_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic              rf_we;

  logic [5:0]        opcode;
  logic [4:0]        sub;
  logic [RI_W-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0] imm, rd_val, rs1_val, rs2_val, alu_res;
  logic              legal;
  logic              unused_inst_bits;

  assign opcode  = inst_q[30:25];
  assign sub     = inst_q[4:0];
  assign rd_idx  = inst_q[20 +: RI_W];
  assign rs1_idx = inst_q[15 +: RI_W];
  assign rs2_idx = inst_q[10 +: RI_W];
  assign imm     = {{(DATA_W-15){inst_q[14]}}, inst_q[14:0]};
  assign rd_val  = (rd_idx  == '0) ? '0 : rf_q[rd_idx];
  assign rs1_val = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
  assign unused_inst_bits = ^{inst_q[31], inst_q[9:5]};

  assign legal = ((opcode == OP_R) && (sub <= 5'd4)) || (opcode == OP_ADDI) ||
                 (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ) ||
                 (opcode == OP_HALT);

  always_comb begin
    alu_res = '0;
    case (sub)
      5'd0: alu_res = a_q + b_q;
      5'd1: alu_res = a_q - b_q;
      5'd2: alu_res = a_q & b_q;
      5'd3: alu_res = a_q | b_q;
      5'd4: alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    case (state_q)
      S_FETCH: if (imem_ack) begin
        inst_d  = imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rs1_val;
        // Stores and branches use the rd field as a second source operand.
        b_d = ((opcode == OP_SW) || (opcode == OP_BEQ)) ? rd_val : rs2_val;
        if (!legal) begin
          illegal_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end else if (opcode == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R:    begin res_d = alu_res;   state_d = S_WB;  end
          OP_ADDI: begin res_d = a_q + imm; state_d = S_WB;  end
          OP_LW,
          OP_SW:   begin res_d = a_q + imm; state_d = S_MEM; end
          OP_BEQ: begin
            pc_d      = (a_q == b_q) ? (pc_q + imm[PC_W-1:0]) : (pc_q + PC_ONE);
            retired_d = retired_q + 16'd1;
            state_d   = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: if (dmem_ack) begin
        if (opcode == OP_SW) begin
          pc_d      = pc_q + PC_ONE;
          retired_d = retired_q + 16'd1;
          state_d   = S_FETCH;
        end else begin
          res_d   = dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we     = (rd_idx != '0);
        pc_d      = pc_q + PC_ONE;
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      inst_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (rf_we) rf_q[rd_idx] <= res_q;
    end
  end

  // Handshake: req is a pure decode of the registered state and stays high with
  // address/data frozen until the cycle ack is seen; that cycle completes the access.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && (opcode == OP_SW);
  assign dmem_addr  = dmem_req ? res_q[DADDR_W-1:0] : '0;
  assign dmem_wdata = dmem_we ? b_q : '0;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign pc         = pc_q;
  assign retired    = retired_q;
endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: memory models with programmable wait states,
// a store scoreboard fed by an expected queue, and end-of-program state checks.
module tb_mc_cpu_core;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int HW = 16;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h1C;
  localparam logic [5:0] OP_SW   = 6'h14;
  localparam logic [5:0] OP_BEQ  = 6'h10;
  localparam logic [31:0] HALT_W = 32'h7E00_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_h = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 32-bit instance
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
  logic [4:0]    imem_addr, pc;
  logic [31:0]   imem_data;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [15:0]   retired;

  mc_cpu_core u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .illegal(illegal), .pc(pc), .retired(retired)
  );

  logic [31:0]   imem [0:31];
  logic [DW-1:0] dmem [0:127];
  int            imem_wait = 0;
  int            dmem_wait = 0;
  logic [7:0]    icnt, dcnt;

  assign imem_ack   = imem_req && (int'(icnt) >= imem_wait);
  assign imem_data  = imem[imem_addr];
  assign dmem_ack   = dmem_req && (int'(dcnt) >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) icnt <= '0; else icnt <= icnt + 8'd1;
    if (rst || !dmem_req || dmem_ack) dcnt <= '0; else dcnt <= dcnt + 8'd1;
    if (!rst && dmem_req && dmem_we && dmem_ack) dmem[dmem_addr] <= dmem_wdata;
  end

  // 16-bit, 8-register instance with zero-wait memories
  logic          imem_req_h, imem_ack_h, dmem_req_h, dmem_we_h, dmem_ack_h, halted_h, illegal_h;
  logic [4:0]    imem_addr_h, pc_h;
  logic [31:0]   imem_data_h;
  logic [AW-1:0] dmem_addr_h;
  logic [HW-1:0] dmem_wdata_h;
  logic [HW-1:0] dmem_rdata_h = '0;
  logic [15:0]   retired_h;
  logic [31:0]   imem_h [0:31];

  mc_cpu_core #(.DATA_W(HW), .NREG(8)) u_dut_h (
    .clk(clk), .rst(rst_h),
    .imem_req(imem_req_h), .imem_addr(imem_addr_h), .imem_ack(imem_ack_h), .imem_data(imem_data_h),
    .dmem_req(dmem_req_h), .dmem_we(dmem_we_h), .dmem_addr(dmem_addr_h), .dmem_wdata(dmem_wdata_h),
    .dmem_ack(dmem_ack_h), .dmem_rdata(dmem_rdata_h),
    .halted(halted_h), .illegal(illegal_h), .pc(pc_h), .retired(retired_h)
  );

  assign imem_ack_h  = imem_req_h;
  assign imem_data_h = imem_h[imem_addr_h];
  assign dmem_ack_h  = dmem_req_h;

  // scoreboards: expected stores {addr, data}
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+HW-1:0] exp_h_q[$];
  int stable_cnt = 0;

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!rst && dmem_req && dmem_we && dmem_addr == 7'd4 && dmem_wdata == 32'd2) stable_cnt++;
    if (!rst && dmem_req && dmem_we && dmem_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL store_unexpected got addr=%0d data=%h expected no store", dmem_addr, dmem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({dmem_addr, dmem_wdata} !== e) begin
          failures++;
          $display("FAIL store got addr=%0d data=%h expected addr=%0d data=%h",
                   dmem_addr, dmem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [AW+HW-1:0] e;
    if (!rst_h && dmem_req_h && dmem_we_h && dmem_ack_h) begin
      checks++;
      if (exp_h_q.size() == 0) begin
        failures++;
        $display("FAIL store16_unexpected got addr=%0d data=%h", dmem_addr_h, dmem_wdata_h);
      end else begin
        e = exp_h_q.pop_front();
        if ({dmem_addr_h, dmem_wdata_h} !== e) begin
          failures++;
          $display("FAIL store16 got addr=%0d data=%h expected addr=%0d data=%h",
                   dmem_addr_h, dmem_wdata_h, e[AW+HW-1:HW], e[HW-1:0]);
        end
      end
    end
  end

  // driver helpers
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int rs1, input int imm);
    logic [31:0] t;
    t = '0;
    t[30:25] = op;
    t[24:20] = rd[4:0];
    t[19:15] = rs1[4:0];
    t[14:0]  = imm[14:0];
    return t;
  endfunction

  function automatic logic [31:0] enc_r(input int sub, input int rd, input int rs1, input int rs2);
    logic [31:0] t;
    t = '0;
    t[24:20] = rd[4:0];
    t[19:15] = rs1[4:0];
    t[14:10] = rs2[4:0];
    t[4:0]   = sub[4:0];
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_st(input int a, input logic [31:0] d);
    exp_q.push_back({a[AW-1:0], d});
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 400) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) dmem[i] = '0;

    // P1: ADDI/ADDI/ADD/HALT, zero-wait
    clear_prog();
    imem[0] = enc_i(OP_ADDI, 1, 0, 5);
    imem[1] = enc_i(OP_ADDI, 2, 0, -3);
    imem[2] = enc_r(0, 3, 1, 2);
    imem[3] = 32'hFE00_0000;
    do_reset();
    chk("reset_imem_req", {31'd0, imem_req}, 32'd1);
    chk("reset_pc", {27'd0, pc}, 32'd0);
    chk("reset_retired", {16'd0, retired}, 32'd0);
    chk("reset_halted", {30'd0, halted, illegal}, 32'd0);
    chk("reset_dmem_outs", {dmem_req, dmem_we, dmem_addr, dmem_wdata[22:0]} , 32'd0);
    chk("reset_dmem_wdata", dmem_wdata, 32'd0);
    repeat (12) cyc();
    chk("p1_retired_after_12", {16'd0, retired}, 32'd3);
    wait_halt("p1_halted");
    chk("p1_illegal", {31'd0, illegal}, 32'd0);
    chk("p1_pc", {27'd0, pc}, 32'd3);
    cyc();
    chk("p1_imem_req_off", {31'd0, imem_req}, 32'd0);

    // P2: store/load with 3 dmem wait states, branches
    clear_prog();
    imem[0]  = enc_i(OP_ADDI, 1, 0, 5);
    imem[1]  = enc_i(OP_ADDI, 2, 0, -3);
    imem[2]  = enc_r(0, 3, 1, 2);
    imem[3]  = enc_i(OP_SW, 3, 0, 4);
    imem[4]  = enc_i(OP_LW, 4, 0, 4);
    imem[5]  = enc_i(OP_SW, 4, 0, 5);
    imem[6]  = enc_i(OP_BEQ, 1, 2, 5);
    imem[7]  = enc_i(OP_BEQ, 3, 4, 3);
    imem[8]  = enc_i(OP_SW, 1, 0, 9);
    imem[9]  = enc_i(OP_SW, 1, 0, 9);
    dmem_wait = 3;
    stable_cnt = 0;
    do_reset();
    push_st(4, 32'd2);
    push_st(5, 32'd2);
    n = 0;
    while (retired != 16'd4 && n < 200) begin
      cyc();
      n++;
    end
    chk("p2_reach_lw", {16'd0, retired}, 32'd4);
    n = 0;
    while (retired == 16'd4 && n < 50) begin
      cyc();
      n++;
    end
    chk("p2_lw_cycles", n, 32'd8);
    wait_halt("p2_halted");
    chk("p2_retired", {16'd0, retired}, 32'd8);
    chk("p2_pc", {27'd0, pc}, 32'd10);
    chk("p2_illegal", {31'd0, illegal}, 32'd0);
    chk("p2_store_stable_cycles", stable_cnt, 32'd4);
    chk("p2_queue_empty", exp_q.size(), 32'd0);

    // P3: all ALU ops, R0 write discard, address wrap, imem wait states
    clear_prog();
    imem[0]  = enc_i(OP_ADDI, 1, 0, 6);
    imem[1]  = enc_i(OP_ADDI, 2, 0, -3);
    imem[2]  = enc_r(0, 3, 1, 2);
    imem[3]  = enc_r(1, 4, 1, 2);
    imem[4]  = enc_r(2, 5, 1, 2);
    imem[5]  = enc_r(3, 6, 1, 2);
    imem[6]  = enc_r(4, 7, 1, 2);
    imem[7]  = enc_i(OP_ADDI, 0, 0, 7);
    for (int i = 0; i < 6; i++) imem[8+i] = enc_i(OP_SW, (i < 5) ? 3 + i : 0, 0, 10 + i);
    imem[14] = enc_i(OP_SW, 3, 1, 126);
    imem_wait = 2;
    dmem_wait = 0;
    do_reset();
    push_st(10, 32'd3);
    push_st(11, 32'd9);
    push_st(12, 32'd4);
    push_st(13, 32'hFFFF_FFFF);
    push_st(14, 32'hFFFF_FFFB);
    push_st(15, 32'd0);
    push_st(4, 32'd3);
    wait_halt("p3_halted");
    chk("p3_retired", {16'd0, retired}, 32'd15);
    chk("p3_pc", {27'd0, pc}, 32'd15);
    chk("p3_queue_empty", exp_q.size(), 32'd0);

    // P4: backward branch from pc 0 wraps to 30, pc 31 + 1 wraps to 0
    clear_prog();
    imem_wait = 0;
    imem[0]  = enc_i(OP_BEQ, 1, 0, -2);
    imem[30] = enc_i(OP_ADDI, 1, 0, 1);
    imem[31] = enc_i(OP_SW, 1, 0, 6);
    do_reset();
    push_st(6, 32'd1);
    repeat (3) cyc();
    chk("p4_beq_target", {27'd0, pc}, 32'd30);
    chk("p4_beq_retired", {16'd0, retired}, 32'd1);
    wait_halt("p4_halted");
    chk("p4_pc_after_wrap", {27'd0, pc}, 32'd1);
    chk("p4_retired", {16'd0, retired}, 32'd4);
    chk("p4_queue_empty", exp_q.size(), 32'd0);

    // P5: illegal opcode 0x05
    clear_prog();
    imem[0] = enc_i(OP_ADDI, 1, 0, 1);
    imem[1] = enc_i(6'h05, 1, 1, 1);
    do_reset();
    wait_halt("p5_halted");
    chk("p5_illegal", {31'd0, illegal}, 32'd1);
    chk("p5_retired", {16'd0, retired}, 32'd1);
    chk("p5_pc", {27'd0, pc}, 32'd1);
    repeat (5) cyc();
    chk("p5_reqs_off", {30'd0, imem_req, dmem_req}, 32'd0);

    // P6: R-type with sub=7
    clear_prog();
    imem[0] = enc_r(7, 2, 0, 0);
    do_reset();
    wait_halt("p6_halted");
    chk("p6_illegal", {31'd0, illegal}, 32'd1);
    chk("p6_retired", {16'd0, retired}, 32'd0);

    // P7: reset while a store is pending in MEM
    clear_prog();
    imem[0] = enc_i(OP_ADDI, 1, 0, 9);
    imem[1] = enc_i(OP_SW, 1, 0, 2);
    dmem_wait = 100;
    do_reset();
    chk("p7_reset_clears_flags", {30'd0, halted, illegal}, 32'd0);
    n = 0;
    while (!(dmem_req && dmem_we) && n < 50) begin
      cyc();
      n++;
    end
    chk("p7_store_pending", {31'd0, dmem_req}, 32'd1);
    cyc();
    dmem_wait = 0;
    rst = 1'b1;
    cyc();
    chk("p7_rst_drops_dmem_req", {31'd0, dmem_req}, 32'd0);
    cyc();
    rst = 1'b0;
    chk("p7_pc_after_rst", {27'd0, pc}, 32'd0);
    chk("p7_imem_req_after_rst", {31'd0, imem_req}, 32'd1);
    push_st(2, 32'd9);
    wait_halt("p7_halted");
    chk("p7_retired", {16'd0, retired}, 32'd2);
    chk("p7_queue_empty", exp_q.size(), 32'd0);

    // P8: DATA_W=16, NREG=8 instance
    for (int i = 0; i < 32; i++) imem_h[i] = HALT_W;
    imem_h[0] = enc_i(OP_ADDI, 9, 0, 16'h3FFF);
    imem_h[1] = enc_i(OP_SW, 1, 0, 1);
    imem_h[2] = enc_i(OP_ADDI, 1, 1, 16'h3FFF);
    imem_h[3] = enc_i(OP_ADDI, 1, 1, 1);
    imem_h[4] = enc_i(OP_ADDI, 2, 1, 1);
    imem_h[5] = enc_i(OP_SW, 2, 0, 2);
    exp_h_q.push_back({7'd1, 16'h3FFF});
    exp_h_q.push_back({7'd2, 16'h8000});
    cyc();
    rst_h = 1'b0;
    n = 0;
    while (!halted_h && n < 200) begin
      cyc();
      n++;
    end
    chk("p8_halted", {31'd0, halted_h}, 32'd1);
    chk("p8_illegal", {31'd0, illegal_h}, 32'd0);
    chk("p8_retired", {16'd0, retired_h}, 32'd6);
    chk("p8_queue_empty", exp_h_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
